// File: rtl/debug_unlock_ctrl.sv
// Debug unlock controller: a two-word key sequence opens a timed debug session.
// Failed attempts are counted, and reaching the limit locks the unit until reset.
// Scan mode always aborts or blocks an unlock.
module debug_unlock_ctrl #(
    parameter logic [15:0] KEY0           = 16'hA5C3,
    parameter logic [15:0] KEY1           = 16'h3C5A,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned SESSION_CYCLES = 1024,
    parameter int unsigned GAP_CYCLES     = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        key_valid,
    input  logic [15:0] key_data,
    output logic        key_ready,
    input  logic        relock,
    input  logic        scan_mode,
    output logic        debug_unlocked,
    output logic        lockout,
    output logic [1:0]  fail_count
);

    localparam logic [7:0]  GapLoad  = 8'(GAP_CYCLES);
    localparam logic [15:0] SessLoad = 16'(SESSION_CYCLES);
    localparam logic [1:0]  MaxFails = 2'(MAX_FAILS);

    typedef enum logic [1:0] {
        StIdle,
        StGotFirst,
        StUnlocked,
        StLockout
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  gap_q, gap_d;
    logic [15:0] sess_q, sess_d;
    logic [1:0]  fail_q, fail_d;
    logic        key_ready_q, key_ready_d;
    logic        unlocked_q, unlocked_d;
    logic        lockout_q, lockout_d;

    logic        xfer;
    logic        fail_event;
    logic [1:0]  fail_inc;

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        sess_d     = sess_q;
        fail_d     = fail_q;
        fail_event = 1'b0;
        // Scan mode vetoes any transfer offered on the same edge.
        xfer       = key_valid & key_ready_q & ~scan_mode;
        // Saturating increment so the count never wraps.
        fail_inc   = (fail_q == 2'd3) ? fail_q : fail_q + 2'd1;

        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    if (key_data == KEY0) begin
                        state_d = StGotFirst;
                        gap_d   = GapLoad;
                    end else begin
                        fail_event = 1'b1;
                    end
                end
            end
            StGotFirst: begin
                if (scan_mode) begin
                    state_d = StIdle;
                    gap_d   = '0;
                end else if (xfer) begin
                    if (key_data == KEY1) begin
                        state_d = StUnlocked;
                        sess_d  = SessLoad;
                        fail_d  = '0;
                        gap_d   = '0;
                    end else begin
                        fail_event = 1'b1;
                    end
                end else if (gap_q <= 8'd1) begin
                    // Decrement reaches zero on this idle edge: the window is gone.
                    fail_event = 1'b1;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            StUnlocked: begin
                // Counter at 1 means this is the last cycle of the session.
                if (scan_mode || relock || (sess_q <= 16'd1)) begin
                    state_d = StIdle;
                    sess_d  = '0;
                end else begin
                    sess_d = sess_q - 16'd1;
                end
            end
            StLockout: begin
                state_d = StLockout;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (fail_event) begin
            fail_d  = fail_inc;
            gap_d   = '0;
            state_d = (fail_inc == MaxFails) ? StLockout : StIdle;
        end

        key_ready_d = ((state_d == StIdle) || (state_d == StGotFirst)) && !scan_mode;
        unlocked_d  = (state_d == StUnlocked);
        lockout_d   = (state_d == StLockout);
    end

    // State, counters and outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            gap_q       <= '0;
            sess_q      <= '0;
            fail_q      <= '0;
            key_ready_q <= 1'b0;
            unlocked_q  <= 1'b0;
            lockout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            sess_q      <= sess_d;
            fail_q      <= fail_d;
            key_ready_q <= key_ready_d;
            unlocked_q  <= unlocked_d;
            lockout_q   <= lockout_d;
        end
    end

    assign key_ready      = key_ready_q;
    assign debug_unlocked = unlocked_q;
    assign lockout        = lockout_q;
    assign fail_count     = fail_q;

endmodule

// File: tb/tb_debug_unlock_ctrl.sv
// Directed testbench for debug_unlock_ctrl with default parameters.
module tb_debug_unlock_ctrl;

    logic        clk;
    logic        resetn;
    logic        key_valid;
    logic [15:0] key_data;
    logic        key_ready;
    logic        relock;
    logic        scan_mode;
    logic        debug_unlocked;
    logic        lockout;
    logic [1:0]  fail_count;

    int n_total = 0;
    int n_bad   = 0;

    debug_unlock_ctrl dut (
        .clk            (clk),
        .resetn         (resetn),
        .key_valid      (key_valid),
        .key_data       (key_data),
        .key_ready      (key_ready),
        .relock         (relock),
        .scan_mode      (scan_mode),
        .debug_unlocked (debug_unlocked),
        .lockout        (lockout),
        .fail_count     (fail_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance n edges; sample 1 time unit after the last edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one key word for exactly one edge.
    task automatic send(input logic [15:0] k);
        key_valid = 1'b1;
        key_data  = k;
        tick(1);
        key_valid = 1'b0;
        key_data  = 16'h0000;
    endtask

    initial begin
        resetn    = 1'b0;
        key_valid = 1'b0;
        key_data  = 16'h0000;
        relock    = 1'b0;
        scan_mode = 1'b0;

        // Reset state
        #3;
        check_eq("rst_ready", {31'b0, key_ready}, 32'd0);
        check_eq("rst_unlk", {31'b0, debug_unlocked}, 32'd0);
        check_eq("rst_lock", {31'b0, lockout}, 32'd0);
        check_eq("rst_fail", {30'b0, fail_count}, 32'd0);
        #9 resetn = 1'b1;
        tick(1);
        check_eq("rel_ready", {31'b0, key_ready}, 32'd1);

        // Good unlock, full 1024-cycle session
        send(16'hA5C3);
        check_eq("k0_unlk", {31'b0, debug_unlocked}, 32'd0);
        check_eq("k0_ready", {31'b0, key_ready}, 32'd1);
        send(16'h3C5A);
        check_eq("k1_unlk", {31'b0, debug_unlocked}, 32'd1);
        check_eq("k1_ready", {31'b0, key_ready}, 32'd0);
        check_eq("k1_fail", {30'b0, fail_count}, 32'd0);
        tick(1023);
        check_eq("sess_last", {31'b0, debug_unlocked}, 32'd1);
        tick(1);
        check_eq("sess_end", {31'b0, debug_unlocked}, 32'd0);
        check_eq("sess_ready", {31'b0, key_ready}, 32'd1);

        // Gap timeout after 16 idle cycles, success after 15
        send(16'hA5C3);
        tick(15);
        check_eq("gap15_fail", {30'b0, fail_count}, 32'd0);
        tick(1);
        check_eq("gap16_fail", {30'b0, fail_count}, 32'd1);
        check_eq("gap16_ready", {31'b0, key_ready}, 32'd1);
        send(16'hA5C3);
        tick(15);
        send(16'h3C5A);
        check_eq("gap15_unlk", {31'b0, debug_unlocked}, 32'd1);
        check_eq("gap15_clr", {30'b0, fail_count}, 32'd0);

        // Relock at session cycle 10
        tick(9);
        check_eq("pre_relock", {31'b0, debug_unlocked}, 32'd1);
        relock = 1'b1;
        tick(1);
        relock = 1'b0;
        check_eq("relock_unlk", {31'b0, debug_unlocked}, 32'd0);
        check_eq("relock_ready", {31'b0, key_ready}, 32'd1);

        // Scan mode ends a session and blocks key transfers
        send(16'hA5C3);
        send(16'h3C5A);
        check_eq("scan_pre", {31'b0, debug_unlocked}, 32'd1);
        tick(3);
        scan_mode = 1'b1;
        tick(1);
        check_eq("scan_unlk", {31'b0, debug_unlocked}, 32'd0);
        check_eq("scan_ready", {31'b0, key_ready}, 32'd0);
        send(16'h1234);
        check_eq("scan_nofail", {30'b0, fail_count}, 32'd0);
        check_eq("scan_ready2", {31'b0, key_ready}, 32'd0);
        scan_mode = 1'b0;
        tick(1);
        check_eq("scan_off_rdy", {31'b0, key_ready}, 32'd1);

        // Scan raised on the KEY1 transfer edge aborts without a failure
        send(16'hA5C3);
        key_valid = 1'b1;
        key_data  = 16'h3C5A;
        scan_mode = 1'b1;
        tick(1);
        key_valid = 1'b0;
        check_eq("abort_unlk", {31'b0, debug_unlocked}, 32'd0);
        check_eq("abort_fail", {30'b0, fail_count}, 32'd0);
        scan_mode = 1'b0;
        tick(1);
        // Back in IDLE, so a lone KEY1 word is a failure
        send(16'h3C5A);
        check_eq("abort_idle", {30'b0, fail_count}, 32'd1);
        check_eq("abort_unlk2", {31'b0, debug_unlocked}, 32'd0);

        // Asynchronous reset mid-session
        send(16'hA5C3);
        send(16'h3C5A);
        tick(5);
        check_eq("mid_unlk", {31'b0, debug_unlocked}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        check_eq("arst_unlk", {31'b0, debug_unlocked}, 32'd0);
        check_eq("arst_ready", {31'b0, key_ready}, 32'd0);
        #2 resetn = 1'b1;
        tick(1);
        check_eq("arst_rel_rdy", {31'b0, key_ready}, 32'd1);

        // Three bad words lead to lockout
        send(16'h1234);
        check_eq("bad1", {30'b0, fail_count}, 32'd1);
        check_eq("bad1_lock", {31'b0, lockout}, 32'd0);
        send(16'h1234);
        check_eq("bad2", {30'b0, fail_count}, 32'd2);
        send(16'h1234);
        check_eq("bad3", {30'b0, fail_count}, 32'd3);
        check_eq("bad3_lock", {31'b0, lockout}, 32'd1);
        check_eq("bad3_ready", {31'b0, key_ready}, 32'd0);
        send(16'hA5C3);
        send(16'h3C5A);
        relock = 1'b1;
        tick(2);
        relock = 1'b0;
        check_eq("lk_unlk", {31'b0, debug_unlocked}, 32'd0);
        check_eq("lk_sticky", {31'b0, lockout}, 32'd1);
        check_eq("lk_fail", {30'b0, fail_count}, 32'd3);

        // Reset clears lockout asynchronously
        #2 resetn = 1'b0;
        #1;
        check_eq("lk_rst_lock", {31'b0, lockout}, 32'd0);
        check_eq("lk_rst_fail", {30'b0, fail_count}, 32'd0);
        #2 resetn = 1'b1;
        tick(1);
        check_eq("lk_rel_rdy", {31'b0, key_ready}, 32'd1);
        send(16'hA5C3);
        send(16'h3C5A);
        check_eq("post_unlk", {31'b0, debug_unlocked}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
